// File: rtl/corr_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : corr_slot_timer
// Description : Slot timer started by a page-correlator hit. Counts 1 us ticks
//               across up to four 625 us slots, emitting one-cycle pulses at
//               each half-slot point and slot end, then returns to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module corr_slot_timer (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       p_1us,
    input  logic       ps_corre_threshold,
    input  logic       timer_abort,
    output logic       page_rx_endp,
    output logic       corre_tslotdly_endp,
    output logic       corre_halftslotdly_endp,
    output logic       corr_2tslotdly_endp,
    output logic       corr_3tslotdly_endp,
    output logic       corr_4tslotdly_endp,
    output logic       timer_busy,
    output logic [2:0] counter_tslot
);

    // Initial count after a hit: 4 us preamble + 64 us sync word + pipeline.
    localparam logic [9:0] C_LOAD_1US   = 10'd71;
    localparam logic [9:0] C_SLOT_LAST  = 10'd624;
    localparam logic [9:0] C_HALF_POINT = 10'd302;
    localparam logic [2:0] C_LAST_SLOT  = 3'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_thr_d;
    logic [9:0] r_counter_1us;
    logic [9:0] w_counter_1us_nxt;
    logic [2:0] r_counter_tslot;
    logic [2:0] w_counter_tslot_nxt;

    logic       r_page_rx_endp;
    logic       r_tslot_endp;
    logic       r_half_endp;
    logic       r_2tslot_endp;
    logic       r_3tslot_endp;
    logic       r_4tslot_endp;
    logic       r_timer_busy;

    logic       w_trigger;
    logic       w_tick_run;
    logic       w_slot_end;
    logic       w_half_slot;

    // A hit is the rising edge of the correlator level.
    assign w_trigger   = ps_corre_threshold & ~r_thr_d;

    // Tick events only count when neither a new hit nor an abort takes over.
    assign w_tick_run  = (r_state == ST_RUN) & p_1us & ~w_trigger & ~timer_abort;
    assign w_slot_end  = w_tick_run & (r_counter_1us == C_SLOT_LAST);
    assign w_half_slot = w_tick_run & (r_counter_1us == C_HALF_POINT);

    // Next-state and counter update: abort, then hit, then tick advance.
    always_comb begin
        w_state_nxt         = r_state;
        w_counter_1us_nxt   = r_counter_1us;
        w_counter_tslot_nxt = r_counter_tslot;
        if (timer_abort) begin
            w_state_nxt         = ST_IDLE;
            w_counter_1us_nxt   = '0;
            w_counter_tslot_nxt = '0;
        end else if (w_trigger) begin
            w_state_nxt         = ST_RUN;
            w_counter_1us_nxt   = C_LOAD_1US;
            w_counter_tslot_nxt = '0;
        end else if (w_tick_run) begin
            if (r_counter_1us == C_SLOT_LAST) begin
                w_counter_1us_nxt = '0;
                if (r_counter_tslot == C_LAST_SLOT) begin
                    w_state_nxt         = ST_IDLE;
                    w_counter_tslot_nxt = '0;
                end else begin
                    w_counter_tslot_nxt = r_counter_tslot + 3'd1;
                end
            end else begin
                w_counter_1us_nxt = r_counter_1us + 10'd1;
            end
        end
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            r_state         <= ST_IDLE;
            r_thr_d         <= 1'b0;
            r_counter_1us   <= '0;
            r_counter_tslot <= '0;
            r_page_rx_endp  <= 1'b0;
            r_tslot_endp    <= 1'b0;
            r_half_endp     <= 1'b0;
            r_2tslot_endp   <= 1'b0;
            r_3tslot_endp   <= 1'b0;
            r_4tslot_endp   <= 1'b0;
            r_timer_busy    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_thr_d         <= ps_corre_threshold;
            r_counter_1us   <= w_counter_1us_nxt;
            r_counter_tslot <= w_counter_tslot_nxt;
            r_tslot_endp    <= w_slot_end;
            r_half_endp     <= w_half_slot;
            r_page_rx_endp  <= w_slot_end & (r_counter_tslot == 3'd0);
            r_2tslot_endp   <= w_slot_end & (r_counter_tslot == 3'd1);
            r_3tslot_endp   <= w_slot_end & (r_counter_tslot == 3'd2);
            r_4tslot_endp   <= w_slot_end & (r_counter_tslot == 3'd3);
            // Tracks the state register itself, so busy rises with RUN.
            r_timer_busy    <= (w_state_nxt == ST_RUN);
        end
    end

    assign page_rx_endp            = r_page_rx_endp;
    assign corre_tslotdly_endp     = r_tslot_endp;
    assign corre_halftslotdly_endp = r_half_endp;
    assign corr_2tslotdly_endp     = r_2tslot_endp;
    assign corr_3tslotdly_endp     = r_3tslot_endp;
    assign corr_4tslotdly_endp     = r_4tslot_endp;
    assign timer_busy              = r_timer_busy;
    assign counter_tslot           = r_counter_tslot;

endmodule
`default_nettype wire

// File: tb/tb_corr_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_corr_slot_timer
// Description : Scoreboard bench for corr_slot_timer. Expected pulses are
//               derived from tick counts since the last hit and queued; a
//               negedge monitor pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corr_slot_timer;

    logic       clk_6M = 1'b0;
    logic       rstz;
    logic       p_1us;
    logic       ps_corre_threshold;
    logic       timer_abort;
    logic       page_rx_endp;
    logic       corre_tslotdly_endp;
    logic       corre_halftslotdly_endp;
    logic       corr_2tslotdly_endp;
    logic       corr_3tslotdly_endp;
    logic       corr_4tslotdly_endp;
    logic       timer_busy;
    logic [2:0] counter_tslot;

    corr_slot_timer u_dut (
        .clk_6M                  (clk_6M),
        .rstz                    (rstz),
        .p_1us                   (p_1us),
        .ps_corre_threshold      (ps_corre_threshold),
        .timer_abort             (timer_abort),
        .page_rx_endp            (page_rx_endp),
        .corre_tslotdly_endp     (corre_tslotdly_endp),
        .corre_halftslotdly_endp (corre_halftslotdly_endp),
        .corr_2tslotdly_endp     (corr_2tslotdly_endp),
        .corr_3tslotdly_endp     (corr_3tslotdly_endp),
        .corr_4tslotdly_endp     (corr_4tslotdly_endp),
        .timer_busy              (timer_busy),
        .counter_tslot           (counter_tslot)
    );

    always #5 clk_6M = ~clk_6M;

    // Pulse vector bit order: page_rx, tslot, half, corr_2, corr_3, corr_4.
    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;

    // Reference model: a run is described only by ticks seen since the hit.
    bit         m_active  = 1'b0;
    int         m_k       = 0;
    bit         m_thr     = 1'b0;
    bit         m_rst     = 1'b0;
    logic       exp_busy  = 1'b0;
    logic [2:0] exp_tslot = 3'd0;

    function automatic void push_exp(input logic [5:0] v);
        exp_t e;
        e.cyc = cyc;
        e.vec = v;
        q.push_back(e);
    endfunction

    // First slot is 554 ticks long (starts at 71), later ones 625; half-slot
    // points sit 322 ticks before each slot end.
    function automatic void model_step(input bit r, input bit ps, input bit ab, input bit tk);
        bit trig;
        int j;
        cyc++;
        m_rst = !r;
        if (!r) begin
            m_active = 1'b0;
            m_thr    = 1'b0;
        end else begin
            trig  = ps && !m_thr;
            m_thr = ps;
            if (ab) begin
                m_active = 1'b0;
            end else if (trig) begin
                m_active = 1'b1;
                m_k      = 0;
            end else if (m_active && tk) begin
                m_k++;
                if (m_k >= 232 && ((m_k - 232) % 625) == 0)
                    push_exp(6'b001000);
                if (m_k >= 554 && ((m_k - 554) % 625) == 0) begin
                    j = (m_k - 554) / 625;
                    case (j)
                        0:       push_exp(6'b110000);
                        1:       push_exp(6'b010100);
                        2:       push_exp(6'b010010);
                        default: push_exp(6'b010001);
                    endcase
                    if (j == 3) m_active = 1'b0;
                end
            end
        end
        exp_busy  = m_active;
        exp_tslot = (m_active && m_k >= 554) ? 3'(1 + (m_k - 554) / 625) : 3'd0;
    endfunction

    task automatic drive(input bit r, input bit ps, input bit ab, input bit tk);
        rstz               = r;
        ps_corre_threshold = ps;
        timer_abort        = ab;
        p_1us              = tk;
        @(posedge clk_6M);
        model_step(r, ps, ab, tk);
        #1;
    endtask

    task automatic run_ticks(input int n, input bit ps, input int per);
        for (int i = 0; i < n; i++) begin
            repeat (per - 1) drive(1'b1, ps, 1'b0, 1'b0);
            drive(1'b1, ps, 1'b0, 1'b1);
        end
    endtask

    // Monitor: compares pulses against the queue, plus busy/slot each cycle.
    always @(negedge clk_6M) begin
        logic [5:0] dv;
        exp_t       e;
        if (mon_en) begin
            dv = {page_rx_endp, corre_tslotdly_endp, corre_halftslotdly_endp,
                  corr_2tslotdly_endp, corr_3tslotdly_endp, corr_4tslotdly_endp};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse cyc=%0d expected vec=%b never seen", e.cyc, e.vec);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if (dv !== e.vec) begin
                    failures++;
                    $display("FAIL pulse_vec cyc=%0d got=%b want=%b", cyc, dv, e.vec);
                end
            end else if (dv !== 6'b0) begin
                checks++;
                failures++;
                $display("FAIL spurious_pulse cyc=%0d got=%b want=000000", cyc, dv);
            end
            checks++;
            if (timer_busy !== exp_busy) begin
                failures++;
                $display("FAIL timer_busy cyc=%0d got=%b want=%b", cyc, timer_busy, exp_busy);
            end
            checks++;
            if (counter_tslot !== exp_tslot) begin
                failures++;
                $display("FAIL counter_tslot cyc=%0d got=%0d want=%0d", cyc, counter_tslot, exp_tslot);
            end
            if (m_rst) begin
                checks++;
                if ({dv, timer_busy, counter_tslot} !== 10'b0) begin
                    failures++;
                    $display("FAIL reset_outputs cyc=%0d got=%b want=0", cyc,
                             {dv, timer_busy, counter_tslot});
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        bit ps_r;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Basic hit and full four-slot run, ticks every 6th clock.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(2429 + 5, 1'b1, 6);

        // Retrigger at tick 400 of slot 1.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(554 + 400, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(560, 1'b1, 6);
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Abort coincident with a hit, then a clean new hit.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        run_ticks(20, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(300, 1'b1, 6);
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Hit landing on the slot-end tick.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(553, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        run_ticks(560, 1'b1, 6);
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // One-cycle reset mid slot 2 with threshold held high throughout.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(554 + 625 + 100, 1'b1, 6);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run_ticks(600, 1'b1, 6);
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with dense ticks and rare edges/aborts/resets.
        ps_r = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 2999) == 0) ps_r = ~ps_r;
            drive(($urandom_range(0, 9999) != 0), ps_r,
                  ($urandom_range(0, 7999) == 0), ($urandom_range(0, 3) != 0));
        end

        repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk_6M);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d pending want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/corr_slot_timer.md
CORR_SLOT_TIMER -- requirements
Module: corr_slot_timer

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk_6M  in  1  6 MHz system clock; all logic on its rising edge.
- rstz  in  1  reset, synchronous, active-low.
- p_1us  in  1  1 us tick, one clk_6M cycle wide.
- ps_corre_threshold  in  1  correlator hit level from the page correlator.
- timer_abort  in  1  synchronous cancel of any running timing.
- page_rx_endp  out  1  end of the page-response receive slot; fed back to the correlator to clear its hit.
- corre_tslotdly_endp  out  1  pulse at every slot end after a hit.
- corre_halftslotdly_endp  out  1  pulse at every half-slot point.
- corr_2tslotdly_endp  out  1  pulse at the end of slot 2.
- corr_3tslotdly_endp  out  1  pulse at the end of slot 3.
- corr_4tslotdly_endp  out  1  pulse at the end of slot 4.
- timer_busy  out  1  high while in RUN.
- counter_tslot  out  3  current slot index, 0..3.

Function
REQ-002 The block SHALL have a two-state FSM, IDLE and RUN, with a 10-bit counter_1us and a 3-bit counter_tslot.
REQ-003 Trigger: the block SHALL register ps_corre_threshold into thr_d (reset 0); trigger = ps_corre_threshold & ~thr_d.
REQ-004 On trigger in any state, with timer_abort low, the block SHALL:
- load counter_1us = 71 (10'h47; covers 4 us preamble, 64 us sync word and pipeline delay);
- clear counter_tslot to 0;
- enter RUN;
- suppress any endp pulse that would have been produced in that cycle.
REQ-005 In RUN, on a p_1us cycle without trigger, the block SHALL set counter_1us = 0 if counter_1us == 624, else counter_1us + 1.
REQ-006 Slot-end event = RUN & p_1us & counter_1us == 624 & ~trigger. On a slot-end event, counter_tslot SHALL increment, except when it is 3.
REQ-007 Half-slot event = RUN & p_1us & counter_1us == 302 & ~trigger.
REQ-008 Pulse outputs SHALL be registered, asserted for exactly one clk_6M cycle, in the cycle after the event:
- corre_tslotdly_endp on every slot-end event;
- page_rx_endp on a slot-end event with counter_tslot == 0;
- corr_2/3/4tslotdly_endp on a slot-end event with counter_tslot == 1, 2 or 3 respectively;
- corre_halftslotdly_endp on every half-slot event.
REQ-009 A slot-end event with counter_tslot == 3 SHALL return the FSM to IDLE and clear counter_1us and counter_tslot.
REQ-010 In IDLE, counter_1us and counter_tslot SHALL hold 0 and p_1us SHALL be ignored.
REQ-011 timer_abort SHALL have priority over trigger and all events:
- next state IDLE;
- counters cleared;
- no pulse produced from that cycle;
- thr_d still updates.
REQ-012 timer_busy SHALL be a registered output equal to (state == RUN).
REQ-013 A retrigger in RUN SHALL restart timing from slot 0; intervening pulses are lost.

Reset
REQ-014 While rstz is low at a clock edge, the block SHALL force: state IDLE, thr_d 0, counter_1us 0, counter_tslot 0, and all outputs 0.
REQ-015 Reset SHALL override timer_abort and trigger. A ps_corre_threshold already high when rstz deasserts SHALL produce a trigger on the first active cycle.

Verification
REQ-016 Basic hit (p_1us every 6th clock): rising edge on ps_corre_threshold ->
- timer_busy = 1 the next cycle;
- corre_halftslotdly_endp on tick 232;
- page_rx_endp and corre_tslotdly_endp together, one cycle after tick 554.
REQ-017 Full run -> corr_2tslotdly_endp after a further 625 ticks, then corr_3 and corr_4 at 625-tick spacing; timer_busy = 0 the cycle after corr_4; counter_tslot reads 0.
REQ-018 Retrigger at tick 400 of slot 1 -> no corr_2 pulse; page_rx_endp occurs 554 ticks after the retrigger.
REQ-019 timer_abort and trigger in the same cycle -> state stays IDLE, no pulses; a later rising edge (threshold low then high) starts normally.
REQ-020 Trigger coincident with p_1us while counter_1us == 624 -> no endp pulse, counter_1us = 71, counter_tslot = 0.
REQ-021 rstz low for 1 cycle mid-slot 2 -> all outputs 0 the next cycle; threshold held high through reset -> new run starts on the first cycle after reset.
